// File: rtl/usb_status_logger.sv
// USB transaction/bus-reset logger: formats ASCII records into a byte ring drained via inc/q.
// Optional macro USB_LOG_SEQ_EN prefixes every record with a two-digit hex sequence number.
module usb_status_logger #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk48,
  input  logic          rst,
  input  logic          usb_rst,
  input  logic          transaction_active,
  input  logic [3:0]    endpoint,
  input  logic          direction_in,
  input  logic          setup,
  input  logic          data_strobe,
  input  logic          success,
  input  logic          inc,
  output logic [7:0]    q,
  output logic          empty,
  output logic [7:0]    drops,
  output logic [1:0]    state_dbg
);

  // Read handshake: the consumer raises inc; the cycle after the rising edge is seen,
  // q holds the popped byte (or 8'h00 when the buffer was empty). inc must fall
  // before the next pop; a held level pops only once.

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, EMIT = 2'd2} state_t;

`ifdef USB_LOG_SEQ_EN
  localparam logic [3:0] SEQ_LEN = 4'd2;
`else
  localparam logic [3:0] SEQ_LEN = 4'd0;
`endif
  localparam logic [3:0] LEN_T   = 4'd7 + SEQ_LEN;
  localparam logic [3:0] LEN_R   = 4'd3 + SEQ_LEN;
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;

  logic ta_q, usb_rst_q, inc_q;
  logic ta_rise, tx_end, rst_evt, inc_rise, pop;

  logic [3:0] cap_ep;
  logic       cap_dir, cap_setup;
  logic [7:0] cap_cnt;

  logic       pending, rec_is_rst, rec_ack;
  logic [7:0] rec_type, rec_cnt;
  logic [3:0] rec_ep, rec_len;

  state_t     state, state_next;
  logic [3:0] idx, idx_next, fi;
  logic       emit_we, chk_drop, rec_done;
  logic [7:0] rec_byte;
  logic [1:0] drop_n;
  logic [8:0] drop_sum;

`ifdef USB_LOG_SEQ_EN
  logic [7:0] seq;
`endif

  function automatic logic [7:0] hex_digit(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign ta_rise  = transaction_active & ~ta_q;
  assign tx_end   = ta_q & ~transaction_active;
  assign rst_evt  = usb_rst & ~usb_rst_q;
  assign inc_rise = inc & ~inc_q;
  assign pop      = inc_rise & (count != '0);
  assign rec_len  = rec_is_rst ? LEN_R : LEN_T;
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    idx_next   = idx;
    emit_we    = 1'b0;
    chk_drop   = 1'b0;
    rec_done   = 1'b0;
    case (state)
      IDLE: if (pending) state_next = CHECK;
      CHECK: begin
        if ((DEPTH_W - count) >= {{(AW-3){1'b0}}, rec_len}) begin
          state_next = EMIT;
          idx_next   = 4'd0;
        end else begin
          chk_drop   = 1'b1;
          state_next = IDLE;
        end
      end
      EMIT: begin
        emit_we  = 1'b1;
        idx_next = idx + 4'd1;
        if (idx == rec_len - 4'd1) begin
          rec_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte generator: fi is the index within the unprefixed record.
  always_comb begin
    rec_byte = 8'h0A;
    fi       = idx - SEQ_LEN;
    if (rec_is_rst) begin
      case (fi)
        4'd0:    rec_byte = 8'h52;
        4'd1:    rec_byte = 8'h0D;
        default: rec_byte = 8'h0A;
      endcase
    end else begin
      case (fi)
        4'd0:    rec_byte = rec_type;
        4'd1:    rec_byte = hex_digit(rec_ep);
        4'd2:    rec_byte = hex_digit(rec_cnt[7:4]);
        4'd3:    rec_byte = hex_digit(rec_cnt[3:0]);
        4'd4:    rec_byte = rec_ack ? 8'h41 : 8'h4E;
        4'd5:    rec_byte = 8'h0D;
        default: rec_byte = 8'h0A;
      endcase
    end
`ifdef USB_LOG_SEQ_EN
    if (idx == 4'd0)      rec_byte = hex_digit(seq[7:4]);
    else if (idx == 4'd1) rec_byte = hex_digit(seq[3:0]);
`endif
  end

  always_comb begin
    count_next = count + {{AW{1'b0}}, emit_we} - {{AW{1'b0}}, pop};
    drop_n = 2'd0;
    if (pending) begin
      drop_n = {1'b0, rst_evt} + {1'b0, tx_end} + {1'b0, chk_drop};
    end else if (rst_evt && tx_end) begin
      drop_n = 2'd1;
    end
    drop_sum = {1'b0, drops} + {7'd0, drop_n};
  end

  always_ff @(posedge clk48) begin
    if (emit_we && !rst) mem[wr_ptr] <= rec_byte;
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 4'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty      <= 1'b1;
      q          <= 8'h00;
      drops      <= 8'h00;
      ta_q       <= 1'b0;
      usb_rst_q  <= 1'b0;
      inc_q      <= 1'b0;
      cap_ep     <= 4'h0;
      cap_dir    <= 1'b0;
      cap_setup  <= 1'b0;
      cap_cnt    <= 8'h00;
      pending    <= 1'b0;
      rec_is_rst <= 1'b0;
      rec_ack    <= 1'b0;
      rec_type   <= 8'h00;
      rec_cnt    <= 8'h00;
      rec_ep     <= 4'h0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      ta_q      <= transaction_active;
      usb_rst_q <= usb_rst;
      inc_q     <= inc;
      count     <= count_next;
      empty     <= (count_next == '0);
      drops     <= drop_sum[8] ? 8'hFF : drop_sum[7:0];

      if (emit_we) wr_ptr <= wr_ptr + 1'b1;
      if (inc_rise) begin
        if (pop) begin
          q      <= mem[rd_ptr];
          rd_ptr <= rd_ptr + 1'b1;
        end else begin
          q <= 8'h00;
        end
      end

      if (ta_rise) begin
        cap_ep    <= endpoint;
        cap_dir   <= direction_in;
        cap_setup <= setup;
        cap_cnt   <= 8'h00;
      end else if (transaction_active && data_strobe && cap_cnt != 8'hFF) begin
        cap_cnt <= cap_cnt + 8'd1;
      end

      // Record fields are frozen at pending-set so a following transaction cannot corrupt them.
      if (rec_done || chk_drop) begin
        pending <= 1'b0;
      end else if (!pending && rst_evt) begin
        pending    <= 1'b1;
        rec_is_rst <= 1'b1;
      end else if (!pending && tx_end) begin
        pending    <= 1'b1;
        rec_is_rst <= 1'b0;
        rec_ep     <= cap_ep;
        rec_cnt    <= cap_cnt;
        rec_ack    <= success;
        rec_type   <= cap_setup ? 8'h53 : (cap_dir ? 8'h49 : 8'h4F);
      end
    end
  end

`ifdef USB_LOG_SEQ_EN
  always_ff @(posedge clk48) begin
    if (rst)           seq <= 8'h00;
    else if (rec_done) seq <= seq + 8'd1;
  end
`endif

endmodule

// File: tb/tb_usb_status_logger.sv
// Directed bench for usb_status_logger at DEPTH=16; honours USB_LOG_SEQ_EN when defined.
module tb_usb_status_logger;

  logic       clk48 = 1'b0;
  logic       rst, usb_rst, transaction_active, direction_in, setup;
  logic       data_strobe, success, inc;
  logic [3:0] endpoint;
  logic [7:0] q, drops;
  logic       empty;
  logic [1:0] state_dbg;

  logic [7:0] exp_q[$];
  logic [7:0] exp_seq;
  int         n_cmp = 0;
  int         n_bad = 0;
  string      hx = "0123456789ABCDEF";

`ifdef USB_LOG_SEQ_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif

  usb_status_logger #(.DEPTH(16), .AW(4)) dut (
    .clk48(clk48), .rst(rst), .usb_rst(usb_rst),
    .transaction_active(transaction_active), .endpoint(endpoint),
    .direction_in(direction_in), .setup(setup), .data_strobe(data_strobe),
    .success(success), .inc(inc), .q(q), .empty(empty), .drops(drops),
    .state_dbg(state_dbg)
  );

  always #5 clk48 = ~clk48;

  task automatic tick();
    @(posedge clk48);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_rst();
    rst = 1'b1;
    settle(2);
    rst = 1'b0;
    tick();
    exp_q.delete();
    exp_seq = 8'h00;
  endtask

  task automatic do_txn(input logic [3:0] ep, input logic dir, input logic stp,
                        input int nstb, input logic succ);
    endpoint = ep; direction_in = dir; setup = stp; success = succ;
    transaction_active = 1'b1;
    tick();
    for (int i = 0; i < nstb; i++) begin
      data_strobe = 1'b1;
      tick();
    end
    data_strobe = 1'b0;
    transaction_active = 1'b0;
    tick();
  endtask

  task automatic pop_byte(output logic [7:0] b);
    inc = 1'b1;
    tick();
    b = q;
    inc = 1'b0;
    tick();
  endtask

  // Expected-record model: pushes the bytes of one stored record.
  task automatic add_rec(input bit is_rst, input logic [7:0] typ, input logic [3:0] ep,
                         input logic [7:0] cnt, input bit ack);
    if (SEQ_ON) begin
      exp_q.push_back(hx[exp_seq[7:4]]);
      exp_q.push_back(hx[exp_seq[3:0]]);
    end
    exp_seq = exp_seq + 8'd1;
    if (is_rst) begin
      exp_q.push_back("R");
    end else begin
      exp_q.push_back(typ);
      exp_q.push_back(hx[ep]);
      exp_q.push_back(hx[cnt[7:4]]);
      exp_q.push_back(hx[cnt[3:0]]);
      exp_q.push_back(ack ? "A" : "N");
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic test_reset();
    logic [7:0] b;
    do_rst();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b want 1", empty); end
    pop_byte(b);
    n_cmp++; if (b !== 8'h00) begin n_bad++; $display("FAIL reset_q got %h want 00", b); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty_pop got %b want 1", empty); end
    n_cmp++; if (drops !== 8'h00) begin n_bad++; $display("FAIL reset_drops got %h want 00", drops); end
  endtask

  task automatic test_setup();
    logic [7:0] b, e;
    do_rst();
    do_txn(4'h0, 1'b0, 1'b1, 8, 1'b1);
    settle(15);
    add_rec(1'b0, "S", 4'h0, 8'h08, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_byte(b);
      n_cmp++; if (b !== e) begin n_bad++; $display("FAIL setup_byte got %h want %h", b, e); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL setup_empty got %b want 1", empty); end
  endtask

  task automatic test_saturate();
    logic [7:0] b, e;
    do_rst();
    do_txn(4'h3, 1'b1, 1'b0, 300, 1'b0);
    settle(15);
    add_rec(1'b0, "I", 4'h3, 8'hFF, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_byte(b);
      n_cmp++; if (b !== e) begin n_bad++; $display("FAIL sat_byte got %h want %h", b, e); end
    end
  endtask

  task automatic test_usb_reset();
    logic [7:0] b, e;
    do_rst();
    usb_rst = 1'b1; tick(); usb_rst = 1'b0;
    settle(12);
    add_rec(1'b1, 8'h00, 4'h0, 8'h00, 1'b0);
    // Transaction end and bus reset rising in the same cycle.
    endpoint = 4'h5; direction_in = 1'b0; setup = 1'b0; success = 1'b1;
    transaction_active = 1'b1; tick();
    transaction_active = 1'b0; usb_rst = 1'b1; tick();
    usb_rst = 1'b0;
    settle(12);
    add_rec(1'b1, 8'h00, 4'h0, 8'h00, 1'b0);
    n_cmp++; if (drops !== 8'h01) begin n_bad++; $display("FAIL collide_drops got %h want 01", drops); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_byte(b);
      n_cmp++; if (b !== e) begin n_bad++; $display("FAIL usbrst_byte got %h want %h", b, e); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL usbrst_empty got %b want 1", empty); end
  endtask

  task automatic test_full_wrap();
    logic [7:0] b, e;
    do_rst();
    for (int i = 1; i <= 3; i++) begin
      do_txn(4'(i), 1'b0, 1'b0, i, 1'b1);
      settle(15);
    end
    add_rec(1'b0, "O", 4'h1, 8'h01, 1'b1);
    if (!SEQ_ON) add_rec(1'b0, "O", 4'h2, 8'h02, 1'b1);
    n_cmp++;
    if (drops !== (SEQ_ON ? 8'h02 : 8'h01)) begin
      n_bad++; $display("FAIL full_drops got %h want %h", drops, SEQ_ON ? 8'h02 : 8'h01);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_byte(b);
      n_cmp++; if (b !== e) begin n_bad++; $display("FAIL full_byte got %h want %h", b, e); end
    end
    do_txn(4'hA, 1'b1, 1'b0, 26, 1'b0);
    settle(15);
    add_rec(1'b0, "I", 4'hA, 8'h1A, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_byte(b);
      n_cmp++; if (b !== e) begin n_bad++; $display("FAIL wrap_byte got %h want %h", b, e); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL wrap_empty got %b want 1", empty); end
  endtask

  task automatic test_hold_inc();
    logic [7:0] b, e;
    do_rst();
    do_txn(4'h7, 1'b0, 1'b0, 2, 1'b1);
    settle(15);
    add_rec(1'b0, "O", 4'h7, 8'h02, 1'b1);
    inc = 1'b1;
    settle(20);
    inc = 1'b0;
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (q !== e) begin n_bad++; $display("FAIL hold_first got %h want %h", q, e); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_byte(b);
      n_cmp++; if (b !== e) begin n_bad++; $display("FAIL hold_rest got %h want %h", b, e); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL hold_empty got %b want 1", empty); end
  endtask

  task automatic test_rst_emit();
    logic [7:0] b, e;
    int guard;
    do_rst();
    do_txn(4'h2, 1'b1, 1'b0, 4, 1'b1);
    guard = 0;
    while (state_dbg !== 2'd2 && guard < 20) begin tick(); guard++; end
    n_cmp++; if (guard >= 20) begin n_bad++; $display("FAIL emit_reach got timeout want EMIT"); end
    tick();
    do_rst();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rstemit_empty got %b want 1", empty); end
    do_txn(4'h9, 1'b0, 1'b1, 3, 1'b0);
    settle(15);
    add_rec(1'b0, "S", 4'h9, 8'h03, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_byte(b);
      n_cmp++; if (b !== e) begin n_bad++; $display("FAIL rstemit_byte got %h want %h", b, e); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rstemit_end got %b want 1", empty); end
  endtask

  task automatic test_seq();
    string s;
    logic [7:0] b, e;
    do_rst();
    for (int r = 0; r < 2; r++) begin
      do_txn(4'h1, 1'b0, 1'b0, 0, 1'b1);
      settle(15);
    end
    s = "00O100A\r\n01O100A\r\n";
    for (int i = 0; i < s.len(); i++) begin
      e = s[i];
      pop_byte(b);
      n_cmp++; if (b !== e) begin n_bad++; $display("FAIL seq_byte %0d got %h want %h", i, b, e); end
    end
  endtask

  initial begin
    rst = 1'b1; usb_rst = 1'b0; transaction_active = 1'b0; endpoint = 4'h0;
    direction_in = 1'b0; setup = 1'b0; data_strobe = 1'b0; success = 1'b0; inc = 1'b0;
    exp_seq = 8'h00;
    test_reset();
    test_setup();
    test_saturate();
    test_usb_reset();
    test_full_wrap();
    test_hold_inc();
    test_rst_emit();
    if (SEQ_ON) test_seq();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
